// File: rtl/sprite_bus_ctrl_pkg.sv
// Shared definitions for the sprite-memory bus controller: FSM encodings,
// default widths and the grant selection rule used by the IDLE arbiter.
package sprite_bus_ctrl_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int STREAK_W   = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  // Reads win unless the pending write has been starved for a full streak.
  function automatic grant_e pick_grant(input logic rd_req, input logic wr_req,
                                        input logic streak_full);
    if (wr_req && (streak_full || !rd_req)) return GNT_WR;
    if (rd_req) return GNT_RD;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/NBitTristate.sv
// N-bit tristate buffer: drives io with d while en is high, floats it otherwise.
module NBitTristate #(
  parameter int n = 16
) (
  input  logic [n-1:0] d,
  input  logic         en,
  inout  wire  [n-1:0] io
);

  assign io = en ? d : {n{1'bz}};

endmodule

// File: rtl/sprite_bus_ctrl.sv
// Sequences the shared sprite SRAM data bus between the loader (writes) and the
// renderer (reads), keeping a dead cycle between bus-drive direction changes.
module sprite_bus_ctrl
  import sprite_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  inout  wire  [DATA_W-1:0] mem_dq
);

  logic [2:0]          r_state;
  logic                r_drive;
  logic [DATA_W-1:0]   r_dq_out;
  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_full;
  grant_e              w_grant;

  assign w_streak_full = (r_streak == STREAK_W'(MAX_RD_STREAK));
  assign w_grant       = (r_state == ST_IDLE) ? pick_grant(rd_req, wr_req, w_streak_full)
                                              : GNT_NONE;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_drive  <= 1'b0;
      r_streak <= '0;
      mem_addr <= '0;
      mem_we_n <= 1'b1;
      mem_oe_n <= 1'b1;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant == GNT_WR) begin
            r_state  <= ST_WR_SETUP;
            mem_addr <= wr_addr;
            r_drive  <= 1'b1;
            wr_ack   <= 1'b1;
          end else if (w_grant == GNT_RD) begin
            r_state  <= ST_RD;
            mem_addr <= rd_addr;
            mem_oe_n <= 1'b0;
            rd_ack   <= 1'b1;
          end
        end
        ST_RD: begin
          rd_data  <= mem_dq;
          rd_valid <= 1'b1;
          mem_oe_n <= 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          mem_we_n <= 1'b0;
          r_state  <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          mem_we_n <= 1'b1;
          r_state  <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          r_drive <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_drive  <= 1'b0;
          mem_we_n <= 1'b1;
          mem_oe_n <= 1'b1;
        end
      endcase

      // Streak counts reads granted over a waiting writer; any gap in wr_req forgives it.
      if (!wr_req || (w_grant == GNT_WR)) begin
        r_streak <= '0;
      end else if (w_grant == GNT_RD) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_grant == GNT_WR) r_dq_out <= wr_data;
  end

  NBitTristate #(.n(DATA_W)) u_dq (
    .d  (r_dq_out),
    .en (r_drive),
    .io (mem_dq)
  );

endmodule
